// File: rtl/nrx_vram_pkg.sv
// Shared constants and types for the VRAM time-division arbiter.
// Phase numbering follows the four VCLKx4 cycles of one pixel period.
package nrx_vram_pkg;

    localparam int BANK_W     = 8;
    localparam int BANK_DEPTH = 2048;
    localparam int ADR_W      = $clog2(BANK_DEPTH);

    localparam logic [1:0] PH_VID  = 2'd0;
    localparam logic [1:0] PH_VCAP = 2'd1;
    localparam logic [1:0] PH_CPU  = 2'd2;
    localparam logic [1:0] PH_CCAP = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ISSUE,
        DONE
    } cpu_state_e;

endpackage

// File: rtl/nrx_slot_timer.sv
// Pixel phase counter with line realignment; decodes which phase belongs to
// the scanner and which to the CPU for the current pixel.
module nrx_slot_timer
    import nrx_vram_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic linest_i,
    input  logic vblk_i,
    output logic vid_slot_o,
    output logic cpu_slot_o,
    output logic vcap_o
);

    logic [1:0] ph_q;
    logic [1:0] ph_d;
    logic [1:0] phase;
    logic       vcap_q;

    // The LINEST cycle itself is treated as phase 0.
    assign phase = linest_i ? PH_VID : ph_q;

    always_comb begin
        ph_d = ph_q + 2'd1;
        if (linest_i) begin
            ph_d = PH_VCAP;
        end else if (ph_q == PH_CCAP) begin
            ph_d = PH_VID;
        end
    end

    assign vid_slot_o = rst_n_i && (phase == PH_VID) && !vblk_i;
    assign cpu_slot_o = (phase == PH_CPU) || ((phase == PH_VID) && vblk_i);
    assign vcap_o     = vcap_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ph_q   <= PH_VID;
            vcap_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            vcap_q <= vid_slot_o;
        end
    end

endmodule

// File: rtl/nrx_vram_arbiter.sv
// Shares the code/attribute VRAM banks between the video scanner and the Z80,
// stretching CPU cycles with WAITn until the granted access completes.
module nrx_vram_arbiter
    import nrx_vram_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              linest_i,
    input  logic              vblk_i,
    input  logic [ADR_W-1:0]  vadr_i,
    output logic [BANK_W-1:0] vchr_o,
    output logic [BANK_W-1:0] vatr_o,
    output logic              vval_o,
    input  logic              creq_i,
    input  logic              cwe_i,
    input  logic [ADR_W:0]    cadr_i,
    input  logic [BANK_W-1:0] cdi_i,
    output logic [BANK_W-1:0] cdo_o,
    output logic              cack_o,
    output logic              waitn_o,
    output logic [ADR_W-1:0]  radr_o,
    output logic              rce0_o,
    output logic              rce1_o,
    output logic              rwe_o,
    output logic [BANK_W-1:0] rdo_o,
    input  logic [BANK_W-1:0] rdi0_i,
    input  logic [BANK_W-1:0] rdi1_i
);

    logic              vid_slot;
    logic              cpu_slot;
    logic              vid_cap;
    logic              grant;
    cpu_state_e        state_q;
    cpu_state_e        state_d;
    logic              bank_q;
    logic              we_q;
    logic [BANK_W-1:0] vchr_q;
    logic [BANK_W-1:0] vatr_q;
    logic [BANK_W-1:0] cdo_q;
    logic [BANK_W-1:0] rdi_sel;

    nrx_slot_timer u_slot_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .linest_i   (linest_i),
        .vblk_i     (vblk_i),
        .vid_slot_o (vid_slot),
        .cpu_slot_o (cpu_slot),
        .vcap_o     (vid_cap)
    );

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE:    if (creq_i) state_d = PEND;
            PEND: begin
                if (!creq_i) begin
                    state_d = IDLE;
                end else if (cpu_slot) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = DONE;
            DONE:    if (!creq_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Video and CPU slots are disjoint, so at most one branch drives the RAM.
    always_comb begin
        radr_o = '0;
        rce0_o = 1'b0;
        rce1_o = 1'b0;
        rwe_o  = 1'b0;
        rdo_o  = '0;
        if (vid_slot) begin
            radr_o = vadr_i;
            rce0_o = 1'b1;
            rce1_o = 1'b1;
        end else if (grant) begin
            radr_o = cadr_i[ADR_W-1:0];
            rce0_o = !cadr_i[ADR_W];
            rce1_o = cadr_i[ADR_W];
            rwe_o  = cwe_i;
            rdo_o  = cdi_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            bank_q  <= 1'b0;
            we_q    <= 1'b0;
            vchr_q  <= '0;
            vatr_q  <= '0;
            cdo_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                bank_q <= cadr_i[ADR_W];
                we_q   <= cwe_i;
            end
            if (vid_cap) begin
                vchr_q <= rdi0_i;
                vatr_q <= rdi1_i;
            end
            if ((state_q == ISSUE) && !we_q) begin
                cdo_q <= rdi_sel;
            end
        end
    end

    // Captured data is forwarded in the capture cycle and held afterwards.
    assign rdi_sel = bank_q ? rdi1_i : rdi0_i;
    assign vval_o  = vid_cap;
    assign vchr_o  = vid_cap ? rdi0_i : vchr_q;
    assign vatr_o  = vid_cap ? rdi1_i : vatr_q;
    assign cack_o  = (state_q == ISSUE);
    assign cdo_o   = ((state_q == ISSUE) && !we_q) ? rdi_sel : cdo_q;
    assign waitn_o = !(rst_n_i && creq_i && ((state_q == IDLE) || (state_q == PEND)));

endmodule
